sm_clk_edge_meter: RTL and testbench
====================================

Name: sm_clk_edge_meter

Overview:
Receiving end of a divided or external clock such as codec BCLK/LRCLK or a divider output. Synchronises an asynchronous slow clock into the clkIn domain and emits single-cycle rise/fall enable pulses. Measures the slow clock's period in clkIn cycles and flags loss of clock. Downstream audio logic uses the pulses as clock enables instead of clocking on the slow signal directly.

Parameters:
SYNC_STAGES, 2, number of synchroniser flops on sigIn (legal range 2..4)
CNT_W, 16, width of the period counter and the period output
TIMEOUT, 60000, clkIn cycles without a rising edge before lost is asserted; must be < 2**CNT_W

Ports:
clkIn  input  1  system clock; all logic on its rising edge
rst_n  input  1  asynchronous active-low reset
enable  input  1  1 = measure; 0 = hold FSM in IDLE and suppress pulses
sigIn  input  1  asynchronous slow clock to observe
risePulse  output  1  one-cycle pulse per detected rising edge of sigIn
fallPulse  output  1  one-cycle pulse per detected falling edge of sigIn
period  output  CNT_W  last measured rise-to-rise interval, in clkIn cycles
periodStrobe  output  1  one-cycle pulse when period is updated
periodValid  output  1  level; 1 while FSM is LOCKED
lost  output  1  level; set on timeout, cleared on next period capture

Behaviour:
- Reset (async, rst_n=0): sync chain, edge-detect history, cnt and every output = 0. FSM = IDLE. Takes effect immediately, not at the next edge.
- Synchroniser: SYNC_STAGES flops, always clocked, independent of enable. prev = registered copy of the last stage.
- Edge detect: rise = last & ~prev, fall = ~last & prev. risePulse and fallPulse are registered from these and gated by enable.
- Latency: sigIn first sampled high at clkIn edge k gives risePulse high during cycle k+SYNC_STAGES+1 only (3 cycles at default).
- Counter cnt (CNT_W bits):
  - A cycle with rise and enable loads cnt = 1.
  - Otherwise cnt increments, saturating at 2**CNT_W-1.
  - Consecutive rises at internal cycles t0 and t1 leave cnt = t1-t0 at t1.
- FSM states: IDLE, ARMED, LOCKED.
  - IDLE: on rise -> ARMED, cnt=1.
  - ARMED / LOCKED: on rise -> period=cnt, periodStrobe=1 for 1 cycle, lost=0, state LOCKED, cnt=1.
  - ARMED / LOCKED: cnt==TIMEOUT with no rise that cycle -> IDLE, lost=1, periodValid=0. period holds its last value.
  - Rise in the same cycle cnt==TIMEOUT: rise wins. Capture period=TIMEOUT; no timeout.
- enable=0:
  - FSM forced to IDLE, cnt=0.
  - risePulse, fallPulse and periodStrobe held 0.
  - period held; lost held.
  - Sync chain keeps running, so re-enable never produces a stale edge from pre-disable history.
  - After re-enable, two rises are needed before periodValid=1.
- periodValid = (state==LOCKED), registered.
- A glitch shorter than one clkIn cycle may be missed. Any level held for at least one full clkIn cycle is guaranteed to produce exactly one pulse per transition.

Decomposition:
- Shared package: FSM state encoding (IDLE=0, ARMED=1, LOCKED=2) and the default CNT_W/TIMEOUT constants used by the audio clocking blocks.
- One natural sub-module: sm_sync_chain, a parameterised N-flop async-reset synchroniser, reused for other pin inputs such as codec LRCLK and ADCDAT.
- Counter, edge detect and FSM stay in the top module.

Test Plan:
- Reset: hold rst_n=0 with sigIn toggling -> all outputs 0. Release -> no pulses until a sigIn edge passes through the synchroniser.
- SYNC_STAGES=2, CNT_W=8, TIMEOUT=200; sigIn square wave 10 high / 10 low.
  - First risePulse exactly 3 cycles after the first high sample.
  - risePulse and fallPulse each 1 cycle wide, 10 cycles apart.
  - Second rise -> period=20, periodStrobe 1 cycle, periodValid=1.
- Change sigIn to a 50-cycle period -> next strobe gives period=50; periodValid stays 1 throughout.
- Stop sigIn (held low) after lock at 50:
  - Exactly 200 cycles after the last rise, lost=1 and periodValid=0; period stays 50.
  - Restart the 20-cycle wave -> lost clears at the second rise with period=20.
- Rise arrives on the same cycle cnt==200 -> period=200, periodStrobe=1, lost stays 0.
- enable low for 100 cycles mid-lock, sigIn toggling:
  - No pulses, periodValid=0, period held.
  - Re-enable -> periodValid=1 only after the second subsequent rise.
- Async reset pulse mid-LOCKED -> outputs 0 immediately without waiting for a clock edge; FSM in IDLE.

Source files
------------

// File: rtl/sm_clk_edge_meter_pkg.sv
// Shared types and defaults for the audio clocking blocks.
// FSM encoding plus default counter width and timeout.
package sm_clk_edge_meter_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARMED  = 2'd1,
    LOCKED = 2'd2
  } state_t;

  localparam int DEF_CNT_W   = 16;
  localparam int DEF_TIMEOUT = 60000;

endpackage

// File: rtl/sm_sync_chain.sv
// N-flop async-reset synchroniser for slow pin inputs.
// Output is the last flop of the chain.
module sm_sync_chain
  import sm_clk_edge_meter_pkg::*;
#(
  parameter int N = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [N-1:0] s;

  // shift the pin through N flops, always clocked
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) s <= '0;
    else        s <= {s[N-2:0], d};
  end

  assign q = s[N-1];

endmodule

// File: rtl/sm_clk_edge_meter.sv
// Slow-clock receiver: synchronise, edge pulses, period
// measurement and loss-of-clock detection.
module sm_clk_edge_meter
  import sm_clk_edge_meter_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = DEF_CNT_W,
  parameter int TIMEOUT     = DEF_TIMEOUT
) (
  input  logic             clkIn,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             sigIn,
  output logic             risePulse,
  output logic             fallPulse,
  output logic [CNT_W-1:0] period,
  output logic             periodStrobe,
  output logic             periodValid,
  output logic             lost
);

  localparam logic [CNT_W-1:0] TO  = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] MAX = '1;
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  logic             last;
  logic             prev;
  logic             rise;
  logic             fall;
  logic             capture;
  logic             timeout;
  logic [CNT_W-1:0] cnt;
  state_t           state;
  state_t           state_nxt;

  sm_sync_chain #(
    .N(SYNC_STAGES)
  ) u_sync (
    .clk  (clkIn),
    .rst_n(rst_n),
    .d    (sigIn),
    .q    (last)
  );

  assign rise = last & ~prev;
  assign fall = ~last & prev;

  // edge history and enable-gated edge pulses
  always_ff @(posedge clkIn or negedge rst_n) begin
    if (!rst_n) begin
      prev      <= 1'b0;
      risePulse <= 1'b0;
      fallPulse <= 1'b0;
    end else begin
      prev      <= last;
      risePulse <= rise & enable;
      fallPulse <= fall & enable;
    end
  end

  // next state; a rise beats a timeout in the same cycle
  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    timeout   = 1'b0;
    if (!enable) begin
      state_nxt = IDLE;
    end else begin
      unique case (state)
        IDLE: begin
          if (rise) state_nxt = ARMED;
        end
        ARMED, LOCKED: begin
          if (rise) begin
            capture   = 1'b1;
            state_nxt = LOCKED;
          end else if (cnt == TO) begin
            timeout   = 1'b1;
            state_nxt = IDLE;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // state register and registered lock flag
  always_ff @(posedge clkIn or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      periodValid <= 1'b0;
    end else begin
      state       <= state_nxt;
      periodValid <= (state_nxt == LOCKED);
    end
  end

  // rise-to-rise counter, saturating
  always_ff @(posedge clkIn or negedge rst_n) begin
    if (!rst_n)         cnt <= '0;
    else if (!enable)   cnt <= '0;
    else if (rise)      cnt <= ONE;
    else if (cnt != MAX) cnt <= cnt + ONE;
  end

  // period capture, strobe and loss flag
  always_ff @(posedge clkIn or negedge rst_n) begin
    if (!rst_n) begin
      period       <= '0;
      periodStrobe <= 1'b0;
      lost         <= 1'b0;
    end else begin
      periodStrobe <= capture;
      if (capture) period <= cnt;
      if (capture)      lost <= 1'b0;
      else if (timeout) lost <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sm_clk_edge_meter.sv
// Bench for sm_clk_edge_meter: directed and random sigIn
// against a rise-time based reference model.
module tb_sm_clk_edge_meter;

  localparam int TMO = 200;

  logic       clkIn = 1'b0;
  logic       rst_n = 1'b0;
  logic       enable = 1'b1;
  logic       sigIn = 1'b0;
  logic       risePulse;
  logic       fallPulse;
  logic [7:0] period;
  logic       periodStrobe;
  logic       periodValid;
  logic       lost;

  int checks = 0;
  int errors = 0;

  sm_clk_edge_meter #(
    .SYNC_STAGES(2),
    .CNT_W      (8),
    .TIMEOUT    (TMO)
  ) dut (
    .clkIn       (clkIn),
    .rst_n       (rst_n),
    .enable      (enable),
    .sigIn       (sigIn),
    .risePulse   (risePulse),
    .fallPulse   (fallPulse),
    .period      (period),
    .periodStrobe(periodStrobe),
    .periodValid (periodValid),
    .lost        (lost)
  );

  always #5 clkIn = ~clkIn;

  // reference model: sample history, time of last rise
  logic [3:0] hist = '0;
  int  ncyc = 0;
  int  m_last = 0;
  bit  m_have = 0;
  bit  m_rise = 0;
  bit  m_fall = 0;
  bit  m_strobe = 0;
  bit  m_valid = 0;
  bit  m_lost = 0;
  int  m_period = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %0d exp %0d at cycle %0d",
             tag, got, exp, ncyc);
    end
  endtask

  task automatic model_clear();
    hist = '0;
    m_have = 0;
    m_rise = 0;
    m_fall = 0;
    m_strobe = 0;
    m_valid = 0;
    m_lost = 0;
    m_period = 0;
  endtask

  task automatic check_all();
    chk("rise", 32'(risePulse), 32'(m_rise));
    chk("fall", 32'(fallPulse), 32'(m_fall));
    chk("strobe", 32'(periodStrobe), 32'(m_strobe));
    chk("valid", 32'(periodValid), 32'(m_valid));
    chk("lost", 32'(lost), 32'(m_lost));
    chk("period", 32'(period), 32'(m_period));
  endtask

  // one clock: update model at posedge, compare at negedge
  task automatic step();
    bit r, f;
    @(posedge clkIn);
    ncyc++;
    if (!rst_n) begin
      model_clear();
    end else begin
      hist = {hist[2:0], sigIn};
      r = hist[2] & ~hist[3];
      f = ~hist[2] & hist[3];
      m_rise = r & enable;
      m_fall = f & enable;
      m_strobe = 0;
      if (!enable) begin
        m_have = 0;
        m_valid = 0;
      end else if (r) begin
        if (m_have) begin
          m_period = (ncyc - m_last) % 256;
          m_strobe = 1;
          m_valid = 1;
          m_lost = 0;
        end
        m_have = 1;
        m_last = ncyc;
      end else if (m_have && (ncyc - m_last) == TMO) begin
        m_lost = 1;
        m_valid = 0;
        m_have = 0;
      end
    end
    @(negedge clkIn);
    check_all();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic wave(input int hi, input int lo, input int n);
    for (int i = 0; i < n; i++) begin
      sigIn = 1'b1;
      run(hi);
      sigIn = 1'b0;
      run(lo);
    end
  endtask

  initial begin
    // reset held with sigIn toggling
    for (int i = 0; i < 6; i++) begin
      sigIn = ~sigIn;
      step();
    end
    sigIn = 1'b0;
    @(negedge clkIn);
    rst_n = 1'b1;
    run(5);

    // latency: pulse on the third clock after sigIn rises
    sigIn = 1'b1;
    run(2);
    chk("lat_early", 32'(risePulse), 32'd0);
    step();
    chk("lat_hit", 32'(risePulse), 32'd1);
    step();
    chk("lat_width", 32'(risePulse), 32'd0);
    run(6);
    sigIn = 1'b0;
    run(10);
    wave(10, 10, 4);
    chk("p20", 32'(period), 32'd20);
    chk("lock20", 32'(periodValid), 32'd1);

    // 50-cycle period
    wave(25, 25, 4);
    chk("p50", 32'(period), 32'd50);
    chk("lock50", 32'(periodValid), 32'd1);

    // clock stops: timeout
    run(260);
    chk("lost_set", 32'(lost), 32'd1);
    chk("lost_valid", 32'(periodValid), 32'd0);
    chk("lost_hold", 32'(period), 32'd50);

    // restart clears lost
    wave(10, 10, 3);
    chk("relock", 32'(period), 32'd20);
    chk("lost_clr", 32'(lost), 32'd0);

    // rise on the exact timeout cycle
    wave(100, 100, 3);
    chk("p_tmo", 32'(period), 32'd200);
    chk("tmo_nolost", 32'(lost), 32'd0);

    // disable mid-lock
    wave(10, 10, 2);
    enable = 1'b0;
    wave(10, 10, 5);
    chk("dis_hold", 32'(period), 32'd20);
    chk("dis_valid", 32'(periodValid), 32'd0);
    enable = 1'b1;
    wave(10, 10, 1);
    chk("reen_one", 32'(periodValid), 32'd0);
    wave(10, 10, 1);
    chk("reen_two", 32'(periodValid), 32'd1);

    // random segments, with occasional disable
    for (int i = 0; i < 30; i++) begin
      enable = ($urandom_range(0, 7) != 0);
      wave($urandom_range(1, 120), $urandom_range(1, 120), 1);
    end
    enable = 1'b1;

    // async reset mid-lock
    wave(10, 10, 3);
    chk("pre_rst", 32'(periodValid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    model_clear();
    check_all();
    chk("rst_valid", 32'(periodValid), 32'd0);
    chk("rst_period", 32'(period), 32'd0);
    run(2);
    @(negedge clkIn);
    rst_n = 1'b1;
    wave(10, 10, 3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
